// File: rtl/count_scheduler.sv
// Round-robin scheduler sharing one up-counter among REQ sources; one registered add/ack per grant, at most one grant per 3 cycles.
// Outputs registered (1 cycle after the IDLE decision); stops granting at LIMIT until clear_req sequences a clr_n pulse.
module count_scheduler #(
  parameter int REQ   = 4,
  parameter int N     = 4,
  parameter int LIMIT = 20
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [REQ-1:0] req,
  input  logic           clear_req,
  input  logic [N:0]     count,
  output logic           add,
  output logic           clr_n,
  output logic [REQ-1:0] ack,
  output logic           full,
  output logic           busy
);

  localparam int IW = (REQ > 1) ? $clog2(REQ) : 1;
  localparam logic [IW:0]   REQ_W    = (IW+1)'(REQ);
  localparam logic [IW-1:0] LAST_RST = IW'(REQ-1);
  localparam logic [N:0]    LIM      = (N+1)'(LIMIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_WAIT,
    S_FULL,
    S_CLEAR
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [IW-1:0]   r_last;
  logic            r_add;
  logic            r_clr_n;
  logic [REQ-1:0]  r_ack;
  logic            r_full;
  logic            r_busy;

  logic [IW:0]      w_base;
  logic [IW:0]      w_sum;
  logic [IW-1:0]    w_off;
  logic [IW-1:0]    w_win;
  logic [2*REQ-1:0] w_dbl;
  logic [REQ-1:0]   w_rot;
  logic [REQ-1:0]   w_onehot;

  // Rotate req so bit 0 is the source just after the last winner, then take the lowest set bit.
  always_comb begin
    w_base = {1'b0, r_last} + (IW+1)'(1);
    if (w_base >= REQ_W) w_base = '0;
    w_dbl = {req, req} >> w_base;
    w_rot = w_dbl[REQ-1:0];
    w_off = '0;
    for (int i = REQ-1; i >= 0; i--) begin
      if (w_rot[i]) w_off = IW'(i);
    end
    w_sum = w_base + {1'b0, w_off};
    if (w_sum >= REQ_W) w_sum = w_sum - REQ_W;
    w_win = w_sum[IW-1:0];
    w_onehot = '0;
    w_onehot[w_win] = 1'b1;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (clear_req)          w_next = S_CLEAR;
        else if (count >= LIM)  w_next = S_FULL;
        else if (|req)          w_next = S_GRANT;
      end
      S_GRANT: w_next = S_WAIT;
      S_WAIT:  w_next = S_IDLE;
      S_FULL:  if (clear_req) w_next = S_CLEAR;
      S_CLEAR: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every output is a flop and clr_n cannot glitch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_last  <= LAST_RST;
      r_add   <= 1'b0;
      r_ack   <= '0;
      r_clr_n <= 1'b1;
      r_full  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_add   <= (w_next == S_GRANT);
      r_ack   <= (w_next == S_GRANT) ? w_onehot : '0;
      r_clr_n <= (w_next != S_CLEAR);
      r_full  <= (w_next == S_FULL);
      r_busy  <= (w_next == S_GRANT) || (w_next == S_WAIT) || (w_next == S_CLEAR);
      if (w_next == S_GRANT)      r_last <= w_win;
      else if (w_next == S_CLEAR) r_last <= LAST_RST;
    end
  end

  assign add   = r_add;
  assign ack   = r_ack;
  assign clr_n = r_clr_n;
  assign full  = r_full;
  assign busy  = r_busy;

endmodule
